// File: rtl/tlul_err_resp.sv
// TL-UL device-side error responder: sinks one A-channel request at a time and
// answers it with a single d_error D beat after a fixed delay.
package tlul_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 64;
    localparam int TL_AIW = 8;
    localparam int TL_DIW = 1;
    localparam int TL_SZW = 2;
    localparam int TL_DUW = 8;

    localparam logic [2:0] Get           = 3'h4;
    localparam logic [2:0] AccessAck     = 3'h0;
    localparam logic [2:0] AccessAckData = 3'h1;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DW/8-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              a_ready;
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [TL_DIW-1:0] d_sink;
        logic [TL_DW-1:0]  d_data;
        logic [TL_DUW-1:0] d_user;
        logic              d_error;
    } tl_d2h_t;
endpackage

module tlul_err_resp
    import tlul_pkg::*;
#(
    parameter int unsigned RespDelay = 0,
    parameter int unsigned CntW      = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  tl_h2d_t         tl_i,
    output tl_d2h_t         tl_o,
    output logic [CntW-1:0] err_cnt_o,
    output logic            busy_o
);

    if (TL_DW != 64) begin : g_dw_check
        $error("tlul_err_resp supports only a 64-bit data bus");
    end
    if (RespDelay > 15) begin : g_dly_check
        $error("tlul_err_resp RespDelay must be within 0..15");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // WAIT lasts exactly RespDelay cycles, so the counter starts one below it.
    localparam logic [3:0] DlyLoad = (RespDelay == 0) ? 4'd0 : 4'(RespDelay - 1);

    function automatic logic [2:0] resp_opcode(input logic [2:0] a_op);
        return (a_op == Get) ? AccessAckData : AccessAck;
    endfunction

    function automatic logic [TL_DW-1:0] resp_data(input logic [2:0] a_op);
        return (a_op == Get) ? {TL_DW{1'b1}} : {TL_DW{1'b0}};
    endfunction

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
        return (&v) ? v : v + CntW'(1);
    endfunction

    state_e            state_q;
    logic [3:0]        dly_q;
    logic              a_ready_q;
    logic              d_valid_q;
    logic [2:0]        d_opcode_q;
    logic [TL_SZW-1:0] d_size_q;
    logic [TL_AIW-1:0] d_source_q;
    logic [TL_DW-1:0]  d_data_q;
    logic              d_error_q;
    logic [CntW-1:0]   err_cnt_q;
    logic [CntW-1:0]   err_cnt_d;

    assign err_cnt_d = sat_inc(err_cnt_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            dly_q      <= '0;
            a_ready_q  <= 1'b1;
            d_valid_q  <= 1'b0;
            d_opcode_q <= AccessAck;
            d_size_q   <= '0;
            d_source_q <= '0;
            d_data_q   <= '0;
            d_error_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tl_i.a_valid && a_ready_q) begin
                        d_opcode_q <= resp_opcode(tl_i.a_opcode);
                        d_size_q   <= tl_i.a_size;
                        d_source_q <= tl_i.a_source;
                        d_data_q   <= resp_data(tl_i.a_opcode);
                        d_error_q  <= 1'b1;
                        a_ready_q  <= 1'b0;
                        if (RespDelay == 0) begin
                            state_q   <= RESP;
                            d_valid_q <= 1'b1;
                        end else begin
                            dly_q   <= DlyLoad;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dly_q == 4'd0) begin
                        state_q   <= RESP;
                        d_valid_q <= 1'b1;
                    end else begin
                        dly_q <= dly_q - 4'd1;
                    end
                end
                RESP: begin
                    if (tl_i.d_ready) begin
                        state_q    <= IDLE;
                        d_valid_q  <= 1'b0;
                        a_ready_q  <= 1'b1;
                        err_cnt_q  <= err_cnt_d;
                        d_opcode_q <= AccessAck;
                        d_size_q   <= '0;
                        d_source_q <= '0;
                        d_data_q   <= '0;
                        d_error_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    a_ready_q <= 1'b1;
                    d_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        tl_o          = '0;
        tl_o.a_ready  = a_ready_q;
        tl_o.d_valid  = d_valid_q;
        tl_o.d_opcode = d_opcode_q;
        tl_o.d_size   = d_size_q;
        tl_o.d_source = d_source_q;
        tl_o.d_data   = d_data_q;
        tl_o.d_error  = d_error_q;
    end

    assign err_cnt_o = err_cnt_q;
    assign busy_o    = (state_q != IDLE);

    // Address, mask and write data play no part in an error response.
    logic unused_a_fields;
    assign unused_a_fields = ^{tl_i.a_address, tl_i.a_mask, tl_i.a_data};

endmodule
